seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU. Successor to the single-cycle datapath ALU.
//   Adds registered results, a start/done handshake, AND/XOR/SLTU, and iterative
//   signed/unsigned multiply and divide into HI/LO. Sits in the EX stage of the
//   multi-cycle CPU; the control FSM stalls on busy.
// PARAMETERS
//   WIDTH    32  operand/result width, >=4, even
//   OVF_ADD  0   1: ADD also raises overflow; 0: only ADDI does
// PORTS
//   clk       in   1      rising-edge clock (single clock domain)
//   rst_n     in   1      synchronous active-low reset
//   start     in   1      launch op; sampled only when busy==0
//   aluctr    in   4      opcode, see BEHAVIOUR
//   A         in   WIDTH  operand A (rs)
//   B         in   WIDTH  operand B (rt / sign-extended imm)
//   busy      out  1      op in progress; start ignored
//   done      out  1      one-cycle pulse, results valid from this cycle on
//   out       out  WIDTH  result of single-cycle ops (held until next done)
//   hi        out  WIDTH  MULT: upper half; DIV: remainder
//   lo        out  WIDTH  MULT: lower half; DIV: quotient
//   zero      out  1      A==B, captured at accepted start
//   overflow  out  1      signed add overflow (ADDI, or ADD if OVF_ADD)
//   div0      out  1      set by DIV/DIVU with B==0
// BEHAVIOUR
//   Reset (rst_n==0 at posedge): FSM->IDLE; busy, done, out, hi, lo, zero,
//     overflow, div0 all 0. Reset mid-op aborts it; no done is issued.
//   Opcodes: 0000 ADD, 0001 SUB, 0010 OR, 0011 SLT (signed), 0100 ADDI,
//     0101 AND, 0110 XOR, 0111 SLTU, 1000 MULT, 1001 MULTU, 1010 DIV,
//     1011 DIVU. 11xx are undefined: out=0, 1-cycle, flags 0.
//   Accept: posedge with start=1 && busy=0. Operands and opcode are latched;
//     later input changes have no effect on the op in flight.
//   Single-cycle ops: out/zero/overflow update at accept edge, done=1 the
//     following cycle, busy never asserts. hi/lo unchanged.
//   MULT/DIV ops: busy=1 from the accept edge. FSM IDLE->ITER (WIDTH cycles,
//     one shift-add or restoring-subtract step each)->FIX (sign fix, write
//     hi/lo)->IDLE. done pulses, busy drops, exactly WIDTH+1 cycles after
//     accept. out, overflow and zero are unchanged by MDU ops.
//   Signed mult/div operate on magnitudes. Product negated if signs differ.
//     Quotient negative if signs differ; remainder takes the dividend's sign.
//   DIV/DIVU with B==0: no iteration, FIX next cycle; hi=A, lo={WIDTH{1}},
//     div0=1. Any other accepted op clears div0.
//   DIV MIN/-1: lo=MIN, hi=0, no flag.
//   overflow = carry-out of {A[W-1],A}+B differs from bit W-1 (ADDI; ADD if
//     OVF_ADD). Otherwise 0 on single-cycle ops. Add/sub wrap modulo 2^WIDTH.
//   done cycle: busy=0, so a start in the same cycle is accepted back-to-back.
//   start while busy: ignored, no queueing.
// STRUCTURE
//   alu_pkg: opcode localparams (ALU_ADD..ALU_DIVU), FSM state encodings.
//   Sub-module mdu_iter: WIDTH-step shift-add multiplier / restoring divider,
//     with a {acc, q} 2*WIDTH shift register and a step counter
//     ($clog2(WIDTH)+1 bits). seq_alu holds the handshake FSM, the
//     single-cycle datapath, sign pre/post fix and output registers.
// TESTING (WIDTH=32 unless noted)
//   ADDI A=7FFFFFFF B=1 -> next cycle done=1, out=80000000, overflow=1; ADD
//     same operands with OVF_ADD=0 -> overflow=0.
//   SLT A=FFFFFFFF B=1 -> out=1; SLTU same operands -> out=0; SUB 5-5 ->
//     out=0, zero=1.
//   MULT A=FFFFFFFD(-3) B=7 -> busy for 32 cycles, done at +33,
//     hi=FFFFFFFF, lo=FFFFFFEB; MULTU same operands -> hi=6, lo=FFFFFFEB.
//   DIV A=FFFFFFF9(-7) B=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 9/0 -> done
//     at +2, hi=9, lo=FFFFFFFF, div0=1.
//   Back-to-back: start MULT, hold start=1 with ADD while busy -> ADD ignored
//     until the done cycle, accepted there, out valid one cycle later.
//   rst_n=0 at cycle 10 of a DIV -> all outputs 0 next edge, no done pulse;
//     repeat with WIDTH=8 to check the counter and latency (done at +9).

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and handshake-FSM encodings shared by seq_alu and the test environment.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Unsigned iterative multiply (shift-add) / restoring divide on a {acc, q} register pair.
// The first step is taken on the load edge, so WIDTH steps finish WIDTH-1 cycles later.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_acc, r_q, r_b;
    logic             r_div;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_src_acc, w_src_q, w_src_b;
    logic             w_src_div;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_acc, w_nxt_q;

    // NOTE: every signal gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        w_src_acc = r_acc;
        w_src_q   = r_q;
        w_src_b   = r_b;
        w_src_div = r_div;
        if (i_load) begin
            w_src_acc = '0;
            w_src_q   = i_a;
            w_src_b   = i_b;
            w_src_div = i_div;
        end

        w_sum   = {1'b0, w_src_acc} + (w_src_q[0] ? {1'b0, w_src_b} : '0);
        w_shift = {w_src_acc, w_src_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, w_src_b});
        w_diff  = w_shift[WIDTH-1:0] - w_src_b;

        if (w_src_div) begin
            w_nxt_acc = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_nxt_q   = {w_src_q[WIDTH-2:0], w_ge};
        end else begin
            w_nxt_acc = w_sum[WIDTH:1];
            w_nxt_q   = {w_sum[0], w_src_q[WIDTH-1:1]};
        end
    end

    // NOTE: pure datapath with no reset; the owning FSM only reads it after a load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
        if (i_load || i_step) begin
            r_acc <= w_nxt_acc;
            r_q   <= w_nxt_q;
            r_cnt <= i_load ? CW'(1) : r_cnt + CW'(1);
        end
        if (i_load) begin
            r_b   <= i_b;
            r_div <= i_div;
        end
    end

    assign o_acc  = r_acc;
    assign o_q    = r_q;
    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative MULT/DIV into HI/LO,
// with a start/busy/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit OVF_ADD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluctr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             div0
);

    state_t r_state, w_next;

    logic             w_accept, w_is_mdu, w_is_div, w_is_smd, w_undef, w_b_zero;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_acc, w_q, w_quo, w_rem;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic             w_mdu_last;

    logic             r_done, r_zero, r_ovf, r_div0;
    logic [WIDTH-1:0] r_out, r_hi, r_lo, r_a;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_is_mdu = (aluctr[3:2] == 2'b10);
    assign w_undef  = (aluctr[3:2] == 2'b11);
    assign w_is_div = aluctr[1];
    assign w_is_smd = !aluctr[0];
    assign w_b_zero = (B == '0);

    assign w_add   = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    assign w_mag_a = (w_is_smd && A[WIDTH-1]) ? -A : A;
    assign w_mag_b = (w_is_smd && B[WIDTH-1]) ? -B : B;

    always_comb begin
        w_alu_out = '0;
        w_alu_ovf = 1'b0;
        case (aluctr)
            ALU_ADD: begin
                w_alu_out = w_add[WIDTH-1:0];
                w_alu_ovf = OVF_ADD && (w_add[WIDTH] != w_add[WIDTH-1]);
            end
            ALU_ADDI: begin
                w_alu_out = w_add[WIDTH-1:0];
                w_alu_ovf = (w_add[WIDTH] != w_add[WIDTH-1]);
            end
            ALU_SUB:  w_alu_out = A - B;
            ALU_OR:   w_alu_out = A | B;
            ALU_AND:  w_alu_out = A & B;
            ALU_XOR:  w_alu_out = A ^ B;
            ALU_SLT:  w_alu_out = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: w_alu_out = {{(WIDTH-1){1'b0}}, A < B};
            default:  w_alu_out = '0;
        endcase
    end

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .i_load (w_accept && w_is_mdu),
        .i_step (r_state == ST_ITER),
        .i_div  (w_is_div),
        .i_a    (w_mag_a),
        .i_b    (w_mag_b),
        .o_acc  (w_acc),
        .o_q    (w_q),
        .o_last (w_mdu_last)
    );

    // Sign post-fix on magnitude results: product/quotient negate when signs differ,
    // remainder follows the dividend.
    assign w_prod     = {w_acc, w_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -w_q : w_q;
    assign w_rem      = r_neg_r ? -w_acc : w_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_is_mdu) w_next = (w_is_div && w_b_zero) ? ST_FIX : ST_ITER;
            ST_ITER: if (w_mdu_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_is_mdu) begin
            r_a      <= A;
            r_is_div <= w_is_div;
            r_neg_q  <= w_is_smd && (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= w_is_smd && A[WIDTH-1];
            r_dz     <= w_is_div && w_b_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_out  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_div0 <= 1'b0;
                if (!w_is_mdu) begin
                    r_out  <= w_alu_out;
                    r_zero <= !w_undef && (A == B);
                    r_ovf  <= w_alu_ovf;
                    r_done <= 1'b1;
                end
            end
            if (r_state == ST_FIX) begin
                r_done <= 1'b1;
                if (r_dz) begin
                    r_hi   <= r_a;
                    r_lo   <= '1;
                    r_div0 <= 1'b1;
                end else if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign out      = r_out;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign div0     = r_div0;

endmodule
